// File: rtl/param_seq_cu_pkg.sv
// param_seq_cu_pkg: opcodes, FSM state encoding and RF write-source codes
// shared by the sequencer and its decoder.
// The PAUSE state exists only when CU_SINGLE_STEP_EN is defined.
package param_seq_cu_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LDI  = 4'd1;
   localparam logic [3:0] OP_MOV  = 4'd2;
   localparam logic [3:0] OP_ALU  = 4'd3;
   localparam logic [3:0] OP_JZ   = 4'd4;
   localparam logic [3:0] OP_JC   = 4'd5;
   localparam logic [3:0] OP_JMP  = 4'd6;
   localparam logic [3:0] OP_HALT = 4'd7;

   localparam logic [2:0] SRC_ALU   = 3'd0;
   localparam logic [2:0] SRC_CONST = 3'd1;
   localparam logic [2:0] SRC_REG   = 3'd2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
`ifdef CU_SINGLE_STEP_EN
      S_WB     = 3'd4,
      S_PAUSE  = 3'd5
`else
      S_WB     = 3'd4
`endif
   } state_t;

   // Opcodes 8..15 are unassigned and behave exactly like NOP.
   function automatic logic [3:0] norm_op(input logic [3:0] raw);
      return raw[3] ? OP_NOP : raw;
   endfunction

endpackage

// File: rtl/param_seq_cu_decode.sv
// cu_decode: purely combinational split of an instruction word into the
// opcode and the datapath control fields. All fields are passed through for
// every opcode; only the RF write source depends on the opcode.
module cu_decode
   import param_seq_cu_pkg::*;
#(
   parameter int DW   = 8,
   parameter int RA   = 4,
   parameter int PCW  = 6,
   parameter int ALUW = 2,
   parameter int IW   = 4 + 2*RA + DW
) (
   input  logic [IW-1:0]   instr,
   output logic [3:0]      op,
   output logic [DW-1:0]   cu_const,
   output logic [2:0]      in_mux,
   output logic [RA-1:0]   out_mux,
   output logic [RA-1:0]   reg_add,
   output logic [ALUW-1:0] ins_sel,
   output logic [PCW-1:0]  target
);

   // Field extraction and write-source selection
   always_comb begin
      op       = norm_op(instr[IW-1 -: 4]);
      reg_add  = instr[IW-5 -: RA];
      out_mux  = instr[IW-5-RA -: RA];
      cu_const = instr[DW-1:0];
      ins_sel  = instr[ALUW-1:0];
      target   = instr[PCW-1:0];
      in_mux   = SRC_ALU;
      case (op)
         OP_LDI:  in_mux = SRC_CONST;
         OP_MOV:  in_mux = SRC_REG;
         default: in_mux = SRC_ALU;
      endcase
   end

endmodule

// File: rtl/param_seq_cu.sv
// param_seq_cu: program-sequencing control unit. Fetches from a synchronous
// program ROM, decodes into RF/ALU controls, latches Z/CO on ALU ops and
// resolves conditional jumps until HALT.
// Optional: CU_SINGLE_STEP_EN adds a Step input and a PAUSE state entered
// after every completed instruction (except HALT).
//
// Handshake: Start is a level sampled only in IDLE; one sampled high starts
// the program at PC=0 and Busy stays high until the machine returns to IDLE.
// Done pulses for one cycle in the EXEC cycle of HALT (Busy still high, so a
// Start in that cycle is ignored); Busy drops on the following cycle.
module param_seq_cu
   import param_seq_cu_pkg::*;
#(
   parameter int DW   = 8,
   parameter int RA   = 4,
   parameter int PCW  = 6,
   parameter int ALUW = 2,
   parameter int IW   = 4 + 2*RA + DW
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            Start,
`ifdef CU_SINGLE_STEP_EN
   input  logic            Step,
`endif
   input  logic [IW-1:0]   Instr,
   input  logic            Z,
   input  logic            CO,
   output logic [PCW-1:0]  PC,
   output logic [DW-1:0]   CUconst,
   output logic [2:0]      InMuxAdd,
   output logic [RA-1:0]   OutMuxAdd,
   output logic [RA-1:0]   RegAdd,
   output logic            WE,
   output logic [ALUW-1:0] InsSel,
   output logic            Busy,
   output logic            Done,
   output logic [2:0]      dbg_state
);

`ifdef CU_SINGLE_STEP_EN
   localparam state_t S_AFTER = S_PAUSE;
`else
   localparam state_t S_AFTER = S_FETCH;
`endif

   state_t          state_q, state_d;
   logic [PCW-1:0]  pc_q, pc_d;
   logic [3:0]      op_q, op_d;
   logic [PCW-1:0]  tgt_q, tgt_d;
   logic [DW-1:0]   cu_const_q, cu_const_d;
   logic [2:0]      in_mux_q, in_mux_d;
   logic [RA-1:0]   out_mux_q, out_mux_d;
   logic [RA-1:0]   reg_add_q, reg_add_d;
   logic [ALUW-1:0] ins_sel_q, ins_sel_d;
   logic            zf_q, zf_d;
   logic            cf_q, cf_d;
   logic            we_q, we_d;
   logic            done_q, done_d;

   logic [3:0]      dec_op;
   logic [DW-1:0]   dec_const;
   logic [2:0]      dec_in_mux;
   logic [RA-1:0]   dec_out_mux;
   logic [RA-1:0]   dec_reg_add;
   logic [ALUW-1:0] dec_ins_sel;
   logic [PCW-1:0]  dec_target;

   cu_decode #(
      .DW   (DW),
      .RA   (RA),
      .PCW  (PCW),
      .ALUW (ALUW),
      .IW   (IW)
   ) u_decode (
      .instr    (Instr),
      .op       (dec_op),
      .cu_const (dec_const),
      .in_mux   (dec_in_mux),
      .out_mux  (dec_out_mux),
      .reg_add  (dec_reg_add),
      .ins_sel  (dec_ins_sel),
      .target   (dec_target)
   );

   // Next-state, PC, flag and registered-output computation
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      op_d       = op_q;
      tgt_d      = tgt_q;
      cu_const_d = cu_const_q;
      in_mux_d   = in_mux_q;
      out_mux_d  = out_mux_q;
      reg_add_d  = reg_add_q;
      ins_sel_d  = ins_sel_q;
      zf_d       = zf_q;
      cf_d       = cf_q;
      we_d       = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (Start) begin
               pc_d    = '0;
               zf_d    = 1'b0;
               cf_d    = 1'b0;
               state_d = S_FETCH;
            end
         end
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            // ROM data is valid now; capture decoded fields so they stay
            // stable through EXEC and WB.
            op_d       = dec_op;
            tgt_d      = dec_target;
            cu_const_d = dec_const;
            in_mux_d   = dec_in_mux;
            out_mux_d  = dec_out_mux;
            reg_add_d  = dec_reg_add;
            ins_sel_d  = dec_ins_sel;
            done_d     = (dec_op == OP_HALT);
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            case (op_q)
               OP_ALU: begin
                  zf_d    = Z;
                  cf_d    = CO;
                  we_d    = 1'b1;
                  state_d = S_WB;
               end
               OP_LDI, OP_MOV: begin
                  we_d    = 1'b1;
                  state_d = S_WB;
               end
               OP_JZ: begin
                  pc_d    = zf_q ? tgt_q : pc_q + 1'b1;
                  state_d = S_AFTER;
               end
               OP_JC: begin
                  pc_d    = cf_q ? tgt_q : pc_q + 1'b1;
                  state_d = S_AFTER;
               end
               OP_JMP: begin
                  pc_d    = tgt_q;
                  state_d = S_AFTER;
               end
               OP_HALT: state_d = S_IDLE;
               default: begin
                  pc_d    = pc_q + 1'b1;
                  state_d = S_AFTER;
               end
            endcase
         end
         S_WB: begin
            pc_d    = pc_q + 1'b1;
            state_d = S_AFTER;
         end
`ifdef CU_SINGLE_STEP_EN
         S_PAUSE: begin
            if (Step) state_d = S_FETCH;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Sequencer state and registered outputs; reset aborts immediately
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         pc_q       <= '0;
         op_q       <= OP_NOP;
         tgt_q      <= '0;
         cu_const_q <= '0;
         in_mux_q   <= SRC_ALU;
         out_mux_q  <= '0;
         reg_add_q  <= '0;
         ins_sel_q  <= '0;
         zf_q       <= 1'b0;
         cf_q       <= 1'b0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         op_q       <= op_d;
         tgt_q      <= tgt_d;
         cu_const_q <= cu_const_d;
         in_mux_q   <= in_mux_d;
         out_mux_q  <= out_mux_d;
         reg_add_q  <= reg_add_d;
         ins_sel_q  <= ins_sel_d;
         zf_q       <= zf_d;
         cf_q       <= cf_d;
         we_q       <= we_d;
         done_q     <= done_d;
      end
   end

   assign PC        = pc_q;
   assign CUconst   = cu_const_q;
   assign InMuxAdd  = in_mux_q;
   assign OutMuxAdd = out_mux_q;
   assign RegAdd    = reg_add_q;
   assign InsSel    = ins_sel_q;
   assign WE        = we_q;
   assign Done      = done_q;
   assign Busy      = (state_q != S_IDLE);
   assign dbg_state = state_q;

endmodule

// File: tb/tb_param_seq_cu.sv
// tb_param_seq_cu: bench for param_seq_cu. An instruction-level reference
// model turns the ROM contents plus the Z/CO values offered each cycle into
// an expected per-cycle PC/WE/Done/Busy timeline and a queue of expected
// register writes. Set CU_SINGLE_STEP_EN to match the DUT build.
module tb_param_seq_cu;

   localparam int DW   = 8;
   localparam int RA   = 4;
   localparam int PCW  = 6;
   localparam int ALUW = 2;
   localparam int IW   = 4 + 2*RA + DW;
   localparam int WW   = RA + 3 + RA + ALUW + DW;
   localparam int MAXC = 512;
   localparam int ROMN = 1 << PCW;

   // ---------------- clock / reset / DUT ----------------
   logic            clk = 1'b0;
   logic            reset;
   logic            Start;
   logic [IW-1:0]   Instr;
   logic            Z;
   logic            CO;
   logic [PCW-1:0]  PC;
   logic [DW-1:0]   CUconst;
   logic [2:0]      InMuxAdd;
   logic [RA-1:0]   OutMuxAdd;
   logic [RA-1:0]   RegAdd;
   logic            WE;
   logic [ALUW-1:0] InsSel;
   logic            Busy;
   logic            Done;
   logic [2:0]      dbg_state;
`ifdef CU_SINGLE_STEP_EN
   logic            Step;
`endif

   always #5 clk = ~clk;

   param_seq_cu #(.DW(DW), .RA(RA), .PCW(PCW), .ALUW(ALUW)) dut (
      .clk       (clk),
      .reset     (reset),
      .Start     (Start),
`ifdef CU_SINGLE_STEP_EN
      .Step      (Step),
`endif
      .Instr     (Instr),
      .Z         (Z),
      .CO        (CO),
      .PC        (PC),
      .CUconst   (CUconst),
      .InMuxAdd  (InMuxAdd),
      .OutMuxAdd (OutMuxAdd),
      .RegAdd    (RegAdd),
      .WE        (WE),
      .InsSel    (InsSel),
      .Busy      (Busy),
      .Done      (Done),
      .dbg_state (dbg_state)
   );

   // synchronous program ROM: data valid the cycle after PC is presented
   logic [IW-1:0] rom [0:ROMN-1];
   always @(posedge clk) Instr <= rom[PC];

   // ---------------- scoreboard / model storage ----------------
   int n_checks = 0;
   int n_pass   = 0;
   logic [PCW-1:0] exp_pc   [MAXC];
   bit             exp_we   [MAXC];
   bit             exp_done [MAXC];
   bit             exp_busy [MAXC];
   bit             z_arr    [MAXC];
   bit             co_arr   [MAXC];
   logic [WW-1:0]  exp_q[$];

   function automatic logic [IW-1:0] mk(input logic [3:0] op, input logic [3:0] d,
                                        input logic [3:0] s, input logic [7:0] imm);
      return {op, d, s, imm};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < ROMN; i++) rom[i] = '0;
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_reset();
      reset = 1'b0;
      Start = 1'b0;
      Z     = 1'b0;
      CO    = 1'b0;
`ifdef CU_SINGLE_STEP_EN
      Step  = 1'b1;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Instruction-level model: each instruction occupies 4 cycles if it
   // writes the RF, else 3; cycle 1 is the first FETCH after Start.
   task automatic build_model(input int ncyc);
      int pc, c, op, len;
      bit zf, cf, halted;
      logic [IW-1:0] ins;
      logic [3:0] dst, src;
      logic [7:0] imm;
      logic [2:0] mux;
      pc = 0; c = 1; zf = 0; cf = 0; halted = 0;
      exp_q.delete();
      for (int i = 0; i < MAXC; i++) begin
         exp_we[i] = 0; exp_done[i] = 0; exp_busy[i] = 0; exp_pc[i] = '0;
      end
      while (!halted && c <= ncyc) begin
         ins = rom[pc];
         op  = int'(ins[IW-1 -: 4]);
         if (op > 7) op = 0;
         dst = ins[IW-5 -: RA];
         src = ins[IW-5-RA -: RA];
         imm = ins[DW-1:0];
         len = (op >= 1 && op <= 3) ? 4 : 3;
         for (int k = 0; k < len; k++) begin
            exp_pc[c+k]   = PCW'(pc);
            exp_busy[c+k] = 1;
         end
         case (op)
            1, 2, 3: begin
               mux = (op == 1) ? 3'd1 : (op == 2) ? 3'd2 : 3'd0;
               exp_we[c+3] = 1;
               if (c + 3 <= ncyc) exp_q.push_back({dst, mux, src, imm[ALUW-1:0], imm});
               if (op == 3) begin
                  zf = z_arr[c+2];
                  cf = co_arr[c+2];
               end
               pc = (pc + 1) % ROMN;
            end
            4: pc = zf ? (int'(imm) % ROMN) : (pc + 1) % ROMN;
            5: pc = cf ? (int'(imm) % ROMN) : (pc + 1) % ROMN;
            6: pc = int'(imm) % ROMN;
            7: begin
               exp_done[c+2] = 1;
               halted = 1;
            end
            default: pc = (pc + 1) % ROMN;
         endcase
         c += len;
`ifdef CU_SINGLE_STEP_EN
         if (!halted) begin
            exp_pc[c]   = PCW'(pc);
            exp_busy[c] = 1;
            c++;
         end
`endif
      end
      for (; c < MAXC; c++) exp_pc[c] = PCW'(pc);
   endtask

   // Start the ROM program and compare every cycle against the model.
   // zmode: 0 random Z/CO, 1 all ones, 2 all zeros. noise: random Start
   // pulses while the machine is busy.
   task automatic run_prog(input int ncyc, input int zmode, input bit noise);
      logic [WW-1:0] got, want;
      for (int i = 0; i < MAXC; i++) begin
         z_arr[i]  = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
         co_arr[i] = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      build_model(ncyc);
      @(negedge clk);
      Start = 1'b1;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         Start = noise && exp_busy[c] && ($urandom_range(0, 3) == 0);
         Z  = z_arr[c];
         CO = co_arr[c];
         n_checks++;
         if (PC !== exp_pc[c]) $display("FAIL pc cyc=%0d got=%0h exp=%0h", c, PC, exp_pc[c]);
         else n_pass++;
         n_checks++;
         if (WE !== exp_we[c]) $display("FAIL we cyc=%0d got=%b exp=%b", c, WE, exp_we[c]);
         else n_pass++;
         n_checks++;
         if (Done !== exp_done[c]) $display("FAIL done cyc=%0d got=%b exp=%b", c, Done, exp_done[c]);
         else n_pass++;
         n_checks++;
         if (Busy !== exp_busy[c]) $display("FAIL busy cyc=%0d got=%b exp=%b", c, Busy, exp_busy[c]);
         else n_pass++;
         if (WE === 1'b1) begin
            got = {RegAdd, InMuxAdd, OutMuxAdd, InsSel, CUconst};
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL write cyc=%0d got=%h exp=none", c, got);
            else begin
               want = exp_q.pop_front();
               if (got !== want) $display("FAIL write cyc=%0d got=%h exp=%h", c, got, want);
               else n_pass++;
            end
         end
      end
      Start = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) $display("FAIL missing_writes got=0 exp=%0d", exp_q.size());
      else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b0;
      Start = 1'b0;
      #1;
      n_checks++;
      if ({PC, CUconst, InMuxAdd, OutMuxAdd, RegAdd, InsSel, WE, Busy, Done, dbg_state} !== '0)
         $display("FAIL reset_outputs got=%h exp=0",
                  {PC, CUconst, InMuxAdd, OutMuxAdd, RegAdd, InsSel, WE, Busy, Done, dbg_state});
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_ldi_halt();
      apply_reset();
      clear_rom();
      rom[0] = mk(4'd1, 4'd3, 4'd0, 8'h5A);
      rom[1] = mk(4'd7, 4'd0, 4'd0, 8'h00);
      run_prog(14, 0, 0);
   endtask

   task automatic test_alu_jump();
      for (int zm = 1; zm <= 2; zm++) begin
         apply_reset();
         clear_rom();
         rom[0]    = mk(4'd3, 4'd1, 4'd2, 8'h02);
         rom[1]    = mk(4'd4, 4'd0, 4'd0, 8'h10);
         rom[2]    = mk(4'd7, 4'd0, 4'd0, 8'h00);
         rom[16]   = mk(4'd7, 4'd0, 4'd0, 8'h00);
         run_prog(16, zm, 0);
      end
   endtask

   task automatic test_wrap_and_flags();
      apply_reset();
      clear_rom();
      rom[0]  = mk(4'd6, 4'd0, 4'd0, 8'h3F);
      rom[63] = mk(4'd0, 4'd0, 4'd0, 8'h00);
      run_prog(24, 0, 0);
      for (int zm = 1; zm <= 2; zm++) begin
         apply_reset();
         clear_rom();
         rom[0] = mk(4'd3, 4'd1, 4'd1, 8'h00);
         rom[1] = mk(4'd1, 4'd2, 4'd0, 8'h07);
         rom[2] = mk(4'd5, 4'd0, 4'd0, 8'h08);
         rom[3] = mk(4'd7, 4'd0, 4'd0, 8'h00);
         rom[8] = mk(4'd7, 4'd0, 4'd0, 8'h00);
         run_prog(24, zm, 0);
      end
   endtask

   task automatic test_start_while_busy();
      apply_reset();
      clear_rom();
      rom[0] = mk(4'd1, 4'd1, 4'd0, 8'h11);
      rom[1] = mk(4'd2, 4'd2, 4'd1, 8'h00);
      rom[2] = mk(4'd3, 4'd3, 4'd2, 8'h01);
      rom[3] = mk(4'd9, 4'd0, 4'd0, 8'h00);
      rom[4] = mk(4'd6, 4'd0, 4'd0, 8'h06);
      rom[6] = mk(4'd7, 4'd0, 4'd0, 8'h00);
      run_prog(40, 0, 1);
   endtask

   task automatic test_reset_mid_wb();
      apply_reset();
      clear_rom();
      rom[0] = mk(4'd1, 4'd3, 4'd0, 8'h5A);
      rom[1] = mk(4'd7, 4'd0, 4'd0, 8'h00);
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (WE !== 1'b1) $display("FAIL wb_before_reset got=%b exp=1", WE);
      else n_pass++;
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if ({WE, Busy, PC, dbg_state} !== '0)
         $display("FAIL async_abort got=%h exp=0", {WE, Busy, PC, dbg_state});
      else n_pass++;
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         n_checks++;
         if ({WE, Busy} !== 2'b00) $display("FAIL post_reset_idle got=%b exp=00", {WE, Busy});
         else n_pass++;
      end
      run_prog(14, 0, 0);
   endtask

   task automatic test_random();
      logic [3:0] op;
      for (int p = 0; p < 6; p++) begin
         apply_reset();
         for (int i = 0; i < ROMN; i++) begin
            op = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) op = 4'd7;
            rom[i] = mk(op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                        8'($urandom_range(0, 255)));
         end
         run_prog(150, 0, 1);
      end
   endtask

`ifdef CU_SINGLE_STEP_EN
   task automatic test_single_step();
      apply_reset();
      Step = 1'b0;
      clear_rom();
      rom[0] = mk(4'd1, 4'd1, 4'd0, 8'h11);
      rom[1] = mk(4'd1, 4'd2, 4'd0, 8'h22);
      rom[2] = mk(4'd7, 4'd0, 4'd0, 8'h00);
      @(negedge clk);
      Start = 1'b1;
      @(negedge clk);
      Start = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({WE, RegAdd} !== {1'b1, 4'd1}) $display("FAIL step_first_wb got=%h exp=%h", {WE, RegAdd}, {1'b1, 4'd1});
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if ({Busy, WE, PC} !== {1'b1, 1'b0, 6'd1})
            $display("FAIL step_pause got=%h exp=%h", {Busy, WE, PC}, {1'b1, 1'b0, 6'd1});
         else n_pass++;
      end
      Step = 1'b1;
      @(negedge clk);
      Step = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (WE !== 1'b0) $display("FAIL step_early_we got=%b exp=0", WE);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if ({WE, RegAdd, CUconst} !== {1'b1, 4'd2, 8'h22})
         $display("FAIL step_second_wb got=%h exp=%h", {WE, RegAdd, CUconst}, {1'b1, 4'd2, 8'h22});
      else n_pass++;
      Step = 1'b1;
   endtask
`endif

   // global time bound so the bench can never hang
   initial begin
      #1000000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      Instr = '0;
      clear_rom();
      test_reset();
      test_ldi_halt();
      test_alu_jump();
      test_wrap_and_flags();
      test_start_while_busy();
      test_reset_mid_wb();
      test_random();
`ifdef CU_SINGLE_STEP_EN
      test_single_step();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/param_seq_cu.md
Name: param_seq_cu

Overview:
- Parametrised, program-sequencing successor to the single-operation MCU control unit.
- Fetches instruction words from an external synchronous program memory and decodes them into register-file/ALU datapath controls (CUconst, InMuxAdd, OutMuxAdd, RegAdd, WE, InsSel).
- Latches the ALU Z/CO flags and resolves conditional jumps, running a whole program per Start until HALT.
- Sits between program ROM and the RF/ALU datapath.

Parameters:
- DW, 8: datapath/constant width (CUconst, imm field).
- RA, 4: register address bits (RegAdd, OutMuxAdd).
- PCW, 6: program counter width; PCW must be <= DW.
- ALUW, 2: ALU op select width (InsSel).
- IW, 4+2*RA+DW: instruction width, derived; do not override.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  begin program at PC=0; sampled in IDLE only.
- Instr  in  IW  program memory read data, valid the cycle after PC is presented.
- Z  in  1  ALU zero flag, combinational from datapath during EXEC.
- CO  in  1  ALU carry-out, combinational from datapath during EXEC.
- PC  out  PCW  program memory address.
- CUconst  out  DW  immediate constant to datapath.
- InMuxAdd  out  3  RF write source: 0=ALU, 1=CUconst, 2=RF read port (MOV).
- OutMuxAdd  out  RA  RF read (source) register.
- RegAdd  out  RA  RF write (destination) register.
- WE  out  1  RF write enable, one-cycle pulse.
- InsSel  out  ALUW  ALU operation select.
- Busy  out  1  high whenever state != IDLE.
- Done  out  1  one-cycle pulse on HALT.

Behaviour:
- Instruction fields: [IW-1:IW-4] opcode; next RA bits dst; next RA bits src; [DW-1:0] imm.
- ALU op = imm[ALUW-1:0]. Jump target = imm[PCW-1:0].
- Opcodes: 0 NOP, 1 LDI, 2 MOV, 3 ALU, 4 JZ, 5 JC, 6 JMP, 7 HALT. Opcodes 8-15 execute as NOP.
- States: IDLE, FETCH, DECODE, EXEC, WB.
  - IDLE & Start: PC<=0, go to FETCH.
  - FETCH: PC driven, go to DECODE.
  - DECODE: Instr registered into IR; fields drive CUconst, OutMuxAdd, RegAdd, InsSel, InMuxAdd; go to EXEC.
  - EXEC, ALU op: Z/CO latched into flag regs zf/cf at the clock edge ending EXEC; go to WB.
  - EXEC, LDI/MOV: go to WB.
  - EXEC, JZ: PC<=target if zf, else PC+1; go to FETCH. JC is identical using cf.
  - EXEC, JMP: PC<=target; go to FETCH.
  - EXEC, NOP: PC<=PC+1; go to FETCH.
  - EXEC, HALT: Done=1 for one cycle, PC unchanged, go to IDLE.
  - WB: WE=1 for exactly this cycle; PC<=PC+1; go to FETCH.
- Instruction latencies: LDI/MOV/ALU 4 cycles; NOP/jumps 3 cycles; HALT 3 cycles to IDLE.
- Decoded outputs hold steady from DECODE through WB. WE is never high outside WB.
- Flags change only on ALU ops; LDI/MOV/jumps preserve zf/cf. Flags clear on Start.
- PC+1 wraps modulo 2^PCW (last address to 0). Jump to own address is legal (spin loop).
- Start while Busy is ignored. Start in the same cycle Done pulses is ignored; it is accepted from the next cycle.
- Reset values: state IDLE; PC, CUconst, InMuxAdd, OutMuxAdd, RegAdd, InsSel, zf, cf all 0; WE, Busy, Done 0.
- Reset asserted mid-instruction aborts immediately (asynchronously). No pending WE is issued after reset releases.

Optional Feature:
- Macro CU_SINGLE_STEP_EN.
- Defined: adds input Step (1 bit) and state PAUSE. After every completed instruction (WB, or EXEC of NOP/jump), go to PAUSE instead of FETCH. PAUSE holds Busy=1, WE=0, PC already advanced. Step=1 in PAUSE moves to FETCH. HALT still goes directly to IDLE.
- Not defined: no Step port, no PAUSE state; execution is free-running.

Decomposition:
- Package param_seq_cu_pkg:
  - opcode localparams (OP_NOP..OP_HALT);
  - state encoding;
  - InMuxAdd source codes (SRC_ALU, SRC_CONST, SRC_REG).
- One natural sub-module: cu_decode, a combinational IR-to-control mapper.
- The sequencer FSM, PC and flag registers stay in the top module.

Test Plan:
- Reset then Start, ROM {LDI r3,#0x5A; HALT} -> 1st WB cycle 4: RegAdd=3, InMuxAdd=1, CUconst=0x5A, WE=1 one cycle. Done pulses 3 cycles later, then Busy=0.
- ALU r1,r2 op=2 with Z=1 driven in EXEC, then JZ 0x10 -> InsSel=2, OutMuxAdd=2, RegAdd=1. PC=0x10 at next FETCH. Repeat with Z=0: PC=2.
- JMP 0x3F, then NOP at 0x3F -> PC wraps to 0x00. Flags unchanged across LDI between ALU and JC.
- Pulse Start while Busy, mid-program -> ignored; PC sequence unaffected.
- Assert reset during WB of an LDI -> WE, Busy, PC drop to 0 immediately. No write after release; Start restarts at PC=0.
- With CU_SINGLE_STEP_EN, two LDIs -> parks in PAUSE after the first (Busy=1, WE=0). Fetches the second only after Step=1.
